// File: rtl/vd_pkg.sv
// rtl/vd_pkg.sv - shared Viterbi decoder constants, state encodings and trellis helpers
package vd_pkg;
    localparam int HIST = 8;
    localparam int WP_W = 3;
    localparam int PM_W = 4;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        TRACE,
        EMIT
    } tbu_state_t;

    // s = {s1,s0} with s1 newest; stepping back drops s1 and the survivor bit becomes the oldest.
    function automatic logic [1:0] pred(input logic [1:0] s, input logic d);
        return {s[0], d};
    endfunction
endpackage

// File: rtl/tbu_minsel.sv
// rtl/tbu_minsel.sv - 4-way unsigned path metric argmin, ties go to the lowest state index
module tbu_minsel #(
    parameter int PM_W = vd_pkg::PM_W
) (
    input  logic [PM_W-1:0] pm_00,
    input  logic [PM_W-1:0] pm_01,
    input  logic [PM_W-1:0] pm_10,
    input  logic [PM_W-1:0] pm_11,
    output logic [1:0]      sel
);
    import vd_pkg::*;

    logic [PM_W-1:0] lo_a;
    logic [PM_W-1:0] lo_b;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;

    // Strict compares everywhere keep the lower index on equal metrics.
    always_comb begin
        sel_a = S00;
        lo_a  = pm_00;
        if (pm_01 < pm_00) begin
            sel_a = S01;
            lo_a  = pm_01;
        end
        sel_b = S10;
        lo_b  = pm_10;
        if (pm_11 < pm_10) begin
            sel_b = S11;
            lo_b  = pm_11;
        end
        sel = sel_a;
        if (lo_b < lo_a) sel = sel_b;
    end
endmodule

// File: rtl/tbu.sv
// rtl/tbu.sv - survivor traceback unit emitting decoded bits oldest-first, with flush drain
module tbu #(
    parameter int DEPTH = 8,
    parameter int HIST  = vd_pkg::HIST,
    parameter int WP_W  = vd_pkg::WP_W,
    parameter int PM_W  = vd_pkg::PM_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            refresh,
    input  logic            valid_in,
    output logic            in_ready,
    input  logic [WP_W-1:0] write_pointer_in,
    input  logic [HIST-1:0] selected_branch_at_00,
    input  logic [HIST-1:0] selected_branch_at_01,
    input  logic [HIST-1:0] selected_branch_at_10,
    input  logic [HIST-1:0] selected_branch_at_11,
    input  logic [PM_W-1:0] path_metric_00,
    input  logic [PM_W-1:0] path_metric_01,
    input  logic [PM_W-1:0] path_metric_10,
    input  logic [PM_W-1:0] path_metric_11,
    input  logic            flush,
    output logic            decoded_bit,
    output logic            valid_out,
    output logic            last_out,
    output logic            overrun
);
    import vd_pkg::*;

    localparam int              CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    tbu_state_t       state;
    tbu_state_t       state_next;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] pend_inc;
    logic [CNT_W-1:0] pend_after;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] k;
    logic             flush_req;
    logic             flush_mode;
    logic [HIST-1:0]  sb_q [4];
    logic [PM_W-1:0]  pm_q [4];
    logic [WP_W-1:0]  wp_q;
    logic [WP_W-1:0]  k_w;
    logic [WP_W-1:0]  idx;
    logic [1:0]       cur;
    logic [1:0]       start;
    logic [HIST-1:0]  dbuf;
    logic             accept;
    logic             go_normal;
    logic             go_flush;
    logic             trace_done;
    logic             drain_done;

    tbu_minsel #(.PM_W(PM_W)) u_minsel (
        .pm_00 (pm_q[0]),
        .pm_01 (pm_q[1]),
        .pm_10 (pm_q[2]),
        .pm_11 (pm_q[3]),
        .sel   (start)
    );

    assign in_ready   = (state == IDLE);
    assign accept     = valid_in && in_ready;
    assign pend_inc   = (pending == FULL) ? pending : pending + ONE;
    assign pend_after = accept ? pend_inc : pending;
    // A full window always wins; a coincident flush is parked in flush_req and drained next.
    assign go_normal  = accept && (pend_inc == FULL);
    assign go_flush   = in_ready && !go_normal && (flush || flush_req) && (pend_after != '0);
    assign k_w        = WP_W'(k);
    assign idx        = wp_q - k_w;
    assign trace_done = (k == len - ONE);
    assign drain_done = (k == '0);

    assign valid_out   = (state == EMIT);
    assign decoded_bit = valid_out && dbuf[k_w];
    assign last_out    = valid_out && flush_mode && drain_done;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go_normal || go_flush) state_next = SELECT;
            SELECT:  state_next = TRACE;
            TRACE:   if (trace_done) state_next = EMIT;
            EMIT:    if (!flush_mode || drain_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pending    <= '0;
            flush_req  <= 1'b0;
            flush_mode <= 1'b0;
            overrun    <= 1'b0;
            wp_q       <= '0;
            len        <= '0;
            k          <= '0;
            cur        <= S00;
            dbuf       <= '0;
            for (int i = 0; i < 4; i++) begin
                sb_q[i] <= '0;
                pm_q[i] <= '0;
            end
        end else if (refresh) begin
            state      <= IDLE;
            pending    <= '0;
            flush_req  <= 1'b0;
            flush_mode <= 1'b0;
            overrun    <= 1'b0;
            wp_q       <= '0;
            len        <= '0;
            k          <= '0;
            cur        <= S00;
            dbuf       <= '0;
            for (int i = 0; i < 4; i++) begin
                sb_q[i] <= '0;
                pm_q[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (valid_in && !in_ready) overrun <= 1'b1;
            if (flush && (state != IDLE)) flush_req <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pending <= pend_inc;
                        wp_q    <= write_pointer_in;
                        sb_q[0] <= selected_branch_at_00;
                        sb_q[1] <= selected_branch_at_01;
                        sb_q[2] <= selected_branch_at_10;
                        sb_q[3] <= selected_branch_at_11;
                        pm_q[0] <= path_metric_00;
                        pm_q[1] <= path_metric_01;
                        pm_q[2] <= path_metric_10;
                        pm_q[3] <= path_metric_11;
                    end
                    if (go_normal) begin
                        flush_mode <= 1'b0;
                        if (flush) flush_req <= 1'b1;
                    end else if (go_flush) begin
                        flush_mode <= 1'b1;
                    end
                end
                SELECT: begin
                    cur <= start;
                    k   <= '0;
                    len <= pending;
                end
                TRACE: begin
                    dbuf[k_w] <= cur[1];
                    cur       <= pred(cur, sb_q[cur][idx]);
                    if (!trace_done) k <= k + ONE;
                end
                EMIT: begin
                    if (!flush_mode) begin
                        pending <= FULL - ONE;
                    end else if (drain_done) begin
                        pending   <= '0;
                        flush_req <= 1'b0;
                    end else begin
                        k <= k - ONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tbu.sv
// tb/tb_tbu.sv - self-checking bench for tbu against a behavioural traceback model
module tb_tbu;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       refresh = 1'b0;
    logic       valid_in = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] write_pointer_in = '0;
    logic [7:0] sb00 = '0, sb01 = '0, sb10 = '0, sb11 = '0;
    logic [3:0] pm00 = '0, pm01 = '0, pm10 = '0, pm11 = '0;
    logic       in_ready, decoded_bit, valid_out, last_out, overrun;

    always #5 clk = ~clk;

    tbu #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .refresh               (refresh),
        .valid_in              (valid_in),
        .in_ready              (in_ready),
        .write_pointer_in      (write_pointer_in),
        .selected_branch_at_00 (sb00),
        .selected_branch_at_01 (sb01),
        .selected_branch_at_10 (sb10),
        .selected_branch_at_11 (sb11),
        .path_metric_00        (pm00),
        .path_metric_01        (pm01),
        .path_metric_10        (pm10),
        .path_metric_11        (pm11),
        .flush                 (flush),
        .decoded_bit           (decoded_bit),
        .valid_out             (valid_out),
        .last_out              (last_out),
        .overrun               (overrun)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   got_bit[$];
    bit   got_last[$];
    int   got_cyc[$];
    bit   exp_bit[$];
    bit   exp_last[$];
    logic [7:0] nx_sb[4];
    int   nx_pm[4];
    logic [7:0] snap_sb[4];
    int   snap_pm[4];
    int   snap_wp = 0;
    int   wp_next = 0;
    int   m_pend = 0;
    bit   tb_bits[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (valid_out === 1'b1) begin
            got_bit.push_back(decoded_bit);
            got_last.push_back(last_out);
            got_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_q();
        got_bit.delete(); got_last.delete(); got_cyc.delete();
        exp_bit.delete(); exp_last.delete();
    endtask

    // Start at the smallest metric (first wins a tie), decode s/2, step back to 2*(s mod 2)+survivor.
    task automatic model_trace(input int len);
        int best, s;
        best = 0;
        for (int i = 1; i < 4; i++) if (snap_pm[i] < snap_pm[best]) best = i;
        s = best;
        for (int j = 0; j < len; j++) begin
            tb_bits[j] = (s / 2) == 1;
            s = 2 * (s % 2) + int'(snap_sb[s][(snap_wp - j) & 7]);
        end
    endtask

    task automatic model_drain();
        if (m_pend > 0) begin
            model_trace(m_pend);
            for (int j = m_pend - 1; j >= 0; j--) begin
                exp_bit.push_back(tb_bits[j]);
                exp_last.push_back(j == 0);
            end
        end
        m_pend = 0;
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, got_bit.size(), exp_bit.size());
        for (int i = 0; i < got_bit.size() && i < exp_bit.size(); i++) begin
            chk({tag, "_bit"}, got_bit[i], exp_bit[i]);
            chk({tag, "_last"}, got_last[i], exp_last[i]);
        end
        clear_q();
    endtask

    task automatic wait_idle(inout int lows);
        for (int i = 0; i < 100 && in_ready !== 1'b1; i++) begin
            tick();
            if (in_ready !== 1'b1) lows++;
        end
        chk("idle_reached", in_ready, 1);
    endtask

    task automatic set_uniform(input logic [7:0] h, input int m0, input int m1, input int m2, input int m3);
        for (int i = 0; i < 4; i++) nx_sb[i] = h;
        nx_pm[0] = m0; nx_pm[1] = m1; nx_pm[2] = m2; nx_pm[3] = m3;
    endtask

    task automatic set_random();
        for (int i = 0; i < 4; i++) begin
            nx_sb[i] = 8'($urandom);
            nx_pm[i] = $urandom_range(0, 15);
        end
    endtask

    task automatic drive_step();
        sb00 = nx_sb[0]; sb01 = nx_sb[1]; sb10 = nx_sb[2]; sb11 = nx_sb[3];
        pm00 = 4'(nx_pm[0]); pm01 = 4'(nx_pm[1]); pm10 = 4'(nx_pm[2]); pm11 = 4'(nx_pm[3]);
        write_pointer_in = 3'(wp_next);
        valid_in = 1'b1;
    endtask

    task automatic step(input bit fl, input int hold, input string tag);
        int t0, lows, pa;
        bit normal;
        chk({tag, "_ready"}, in_ready, 1);
        drive_step();
        flush = fl;
        for (int i = 0; i < 4; i++) begin
            snap_sb[i] = nx_sb[i];
            snap_pm[i] = nx_pm[i];
        end
        snap_wp = wp_next;
        wp_next = (wp_next + 1) % 8;
        t0 = cyc;
        pa = (m_pend < DEPTH) ? m_pend + 1 : DEPTH;
        normal = (pa == DEPTH);
        if (normal) begin
            model_trace(DEPTH);
            exp_bit.push_back(tb_bits[DEPTH-1]);
            exp_last.push_back(1'b0);
            m_pend = DEPTH - 1;
        end else begin
            m_pend = pa;
        end
        if (fl) model_drain();
        tick();
        lows = (in_ready !== 1'b1) ? 1 : 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (in_ready !== 1'b1) lows++;
        end
        valid_in = 1'b0;
        flush = 1'b0;
        wait_idle(lows);
        if (normal && hold == 0) begin
            chk({tag, "_busy_cycles"}, lows, DEPTH + 2);
            chk({tag, "_emitted"}, got_cyc.size() > 0, 1);
            if (got_cyc.size() > 0) chk({tag, "_latency"}, got_cyc[0] - t0, DEPTH + 2);
        end
        if (normal && fl) begin
            tick();
            wait_idle(lows);
        end
        compare(tag);
    endtask

    task automatic do_flush(input string tag, input int extra);
        int lows;
        lows = 0;
        flush = 1'b1;
        model_drain();
        tick();
        flush = 1'b0;
        wait_idle(lows);
        repeat (extra) tick();
        compare(tag);
    endtask

    task automatic do_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        m_pend = 0;
        clear_q();
        chk("refresh_overrun", overrun, 0);
        chk("refresh_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_decoded_bit", decoded_bit, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        tick();

        set_uniform(8'h00, 0, 15, 15, 15);
        repeat (DEPTH) step(1'b0, 0, "zero");
        chk("zero_overrun", overrun, 0);

        do_refresh();
        set_uniform(8'hFF, 9, 9, 9, 0);
        repeat (DEPTH + 2) step(1'b0, 0, "ones");
        do_flush("ones_flush", 2);

        do_refresh();
        set_uniform(8'h00, 5, 5, 5, 5);
        repeat (DEPTH + 1) step(1'b0, 0, "tie");

        do_refresh();
        repeat (3) begin
            set_random();
            step(1'b0, 0, "three");
        end
        do_flush("three_flush", 2);
        do_flush("empty_flush", 12);

        do_refresh();
        repeat (DEPTH - 1) begin
            set_random();
            step(1'b0, 0, "ovr_fill");
        end
        set_random();
        step(1'b0, 3, "ovr_drop");
        chk("overrun_set", overrun, 1);
        repeat (5) tick();
        chk("overrun_sticky", overrun, 1);
        set_random();
        step(1'b0, 0, "ovr_next");
        chk("overrun_still", overrun, 1);
        do_flush("ovr_flush", 2);
        do_refresh();

        set_uniform(8'h00, 0, 15, 15, 15);
        repeat (DEPTH - 1) step(1'b0, 0, "arst_fill");
        drive_step();
        wp_next = (wp_next + 1) % 8;
        tick();
        valid_in = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_valid_out", valid_out, 0);
        chk("arst_last_out", last_out, 0);
        chk("arst_decoded_bit", decoded_bit, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        m_pend = 0;
        clear_q();
        tick();
        chk("arst_ready_after", in_ready, 1);
        compare("arst_quiet");
        repeat (DEPTH) step(1'b0, 0, "arst_zero");

        do_refresh();
        for (int n = 0; n < 60; n++) begin
            set_random();
            step($urandom_range(0, 5) == 0, 0, "rand");
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 9) == 0) do_flush("rand_flush", 1);
        end
        do_flush("final_flush", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
